// File: rtl/wb_video_arbiter.sv
// ---------------------------------------------------------------------------
// wb_video_arbiter
//   Two-requester Wishbone arbiter sharing one framebuffer bus between the
//   video scanline fetch engine (m0, fixed priority) and the CPU (m1).
//   The CPU is guaranteed a tenure after STARVE_LIMIT consecutive contested
//   video tenures. Every tenure is followed by exactly one idle cycle.
//
//   Optional watchdog: define WB_ARB_TIMEOUT_EN to build it. A granted
//   transfer left unacknowledged for TIMEOUT cycles is terminated with a
//   forced ack carrying 32'hFFFFFFFF, and the sticky timeout_o flag is set.
//   Without the macro timeout_o is tied low and stalls wait forever.
//
// Ports
//   clk_i, rst_n_i        clock, async active-low reset
//   m0_* / m1_*           requester side (cyc, stb, adr, we, sel, dat in,
//                         dat out, ack)
//   bus_*                 shared master port towards the memory slave
//   grant_o               one-hot owner: 01 = m0, 10 = m1, 00 = idle
//   timeout_o             sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module wb_video_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT      = 255
`endif
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // m0: video requester
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  // m1: CPU requester
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [31:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  // shared bus
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic [31:0] bus_adr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_GRANT0 = 2'b01;
  localparam logic [1:0] S_GRANT1 = 2'b10;

  localparam logic [7:0] LP_STARVE = 8'(STARVE_LIMIT);

  logic [1:0]       r_state, w_state_nxt;
  logic [7:0]       r_starve, w_starve_nxt;
  logic             w_busy, w_idx, w_tmo_hit;
  logic             w_fwd_cyc, w_fwd_stb;

  // Requester bundles packed by index (0 = m0, 1 = m1).
  logic [1:0]       w_cyc, w_stb, w_we, w_ack;
  logic [1:0][31:0] w_adr, w_wdat, w_rdat;
  logic [1:0][3:0]  w_sel;

  assign w_cyc  = {m1_cyc_i, m0_cyc_i};
  assign w_stb  = {m1_stb_i, m0_stb_i};
  assign w_we   = {m1_we_i,  m0_we_i};
  assign w_adr  = {m1_adr_i, m0_adr_i};
  assign w_sel  = {m1_sel_i, m0_sel_i};
  assign w_wdat = {m1_dat_i, m0_dat_i};

  assign w_busy  = (r_state != S_IDLE);
  assign w_idx   = r_state[1];
  assign grant_o = r_state;

  // Forward path: straight mux from the owner, zero while idle.
  assign w_fwd_cyc = w_busy & w_cyc[w_idx];
  assign w_fwd_stb = w_busy & w_stb[w_idx];
  assign bus_cyc_o = w_fwd_cyc & ~w_tmo_hit;
  assign bus_stb_o = w_fwd_stb & ~w_tmo_hit;
  assign bus_adr_o = w_busy ? w_adr[w_idx]  : '0;
  assign bus_we_o  = w_busy & w_we[w_idx];
  assign bus_sel_o = w_busy ? w_sel[w_idx]  : '0;
  assign bus_dat_o = w_busy ? w_wdat[w_idx] : '0;

  // Return path: only the granted requester sees ack / read data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign w_ack[gi]  = r_state[gi] & (bus_ack_i | w_tmo_hit);
    assign w_rdat[gi] = !r_state[gi] ? '0 :
                        w_tmo_hit    ? '1 : bus_dat_i;
  end

  assign m0_ack_o = w_ack[0];
  assign m1_ack_o = w_ack[1];
  assign m0_dat_o = w_rdat[0];
  assign m1_dat_o = w_rdat[1];

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

  logic [7:0] r_wd;
  logic       r_timeout;

  assign w_tmo_hit = w_busy & (r_wd == LP_TMO);
  assign timeout_o = r_timeout;

  // Counts stalled cycles of the current owner; restarts on every ack.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_busy || bus_ack_i || w_tmo_hit)
        r_wd <= '0;
      else if (w_fwd_cyc | w_fwd_stb)
        r_wd <= r_wd + 8'd1;
      if (w_tmo_hit)
        r_timeout <= 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Arbitration only happens from idle, so a release always costs one idle
  // cycle before the next owner (including the same requester) is granted.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      S_IDLE: begin
        if (m0_cyc_i && m1_cyc_i && (r_starve == LP_STARVE)) begin
          w_state_nxt  = S_GRANT1;
          w_starve_nxt = '0;
        end else if (m0_cyc_i) begin
          w_state_nxt = S_GRANT0;
          // Only contested video tenures count towards CPU starvation.
          if (!m1_cyc_i)
            w_starve_nxt = '0;
          else if (r_starve != 8'hFF)
            w_starve_nxt = r_starve + 8'd1;
        end else if (m1_cyc_i) begin
          w_state_nxt  = S_GRANT1;
          w_starve_nxt = '0;
        end
      end
      S_GRANT0: if (!m0_cyc_i || w_tmo_hit) w_state_nxt = S_IDLE;
      S_GRANT1: if (!m1_cyc_i || w_tmo_hit) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

endmodule

// File: tb/tb_wb_video_arbiter.sv
module tb_wb_video_arbiter;
  localparam int LIMIT = 4;
  localparam int TMO   = 16;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0, m0_dat_o;
  logic [3:0]  m0_sel_i = 0;
  logic        m0_ack_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_adr_i = 0, m1_dat_i = 0, m1_dat_o;
  logic [3:0]  m1_sel_i = 0;
  logic        m1_ack_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_i = 0;
  logic        bus_ack_i = 0;
  logic [1:0]  grant_o;
  logic        timeout_o;

  wb_video_arbiter #(
    .STARVE_LIMIT(LIMIT)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(TMO)
`endif
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_adr_o(bus_adr_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;

  // Reference model: owner (0 none, 1 m0, 2 m1), contested-tenure tally,
  // stall tally, sticky timeout.
  int m_own = 0, m_starve = 0, m_wd = 0;
  bit m_tmo = 1'b0;

  // Model expectations / DUT observations from the last cycle.
  logic [1:0]  e_grant;
  logic        e_bstb, e_ack0, e_ack1;
  logic [1:0]  o_grant, prev_gnt = 2'b00;
  logic        o_ack1, o_bstb, o_tmo;
  logic [31:0] o_dat1;
  int          ncyc = 0;
  int          tlog[$], tcyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_starve = 0; m_wd = 0; m_tmo = 1'b0;
    prev_gnt = 2'b00;
  endtask

  // One clock: compare at the falling edge, advance the model, return just
  // after the rising edge so the caller can drive next-cycle inputs.
  task automatic step();
    logic        hit, rc, rs, we;
    logic [31:0] adr, wd, d0, d1;
    logic [3:0]  sel;
    @(negedge clk_i);
    hit = TMO_EN && (m_own != 0) && (m_wd == TMO);
    rc  = (m_own == 1) ? m0_cyc_i : (m_own == 2) ? m1_cyc_i : 1'b0;
    rs  = (m_own == 1) ? m0_stb_i : (m_own == 2) ? m1_stb_i : 1'b0;
    adr = (m_own == 1) ? m0_adr_i : (m_own == 2) ? m1_adr_i : 32'h0;
    wd  = (m_own == 1) ? m0_dat_i : (m_own == 2) ? m1_dat_i : 32'h0;
    sel = (m_own == 1) ? m0_sel_i : (m_own == 2) ? m1_sel_i : 4'h0;
    we  = (m_own == 1) ? m0_we_i  : (m_own == 2) ? m1_we_i  : 1'b0;
    e_grant = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
    e_bstb  = rs && !hit;
    e_ack0  = (m_own == 1) && (bus_ack_i || hit);
    e_ack1  = (m_own == 2) && (bus_ack_i || hit);
    d0 = (m_own != 1) ? 32'h0 : hit ? 32'hFFFF_FFFF : bus_dat_i;
    d1 = (m_own != 2) ? 32'h0 : hit ? 32'hFFFF_FFFF : bus_dat_i;

    check("grant",    grant_o,   e_grant);
    check("bus_cyc",  bus_cyc_o, rc && !hit);
    check("bus_stb",  bus_stb_o, e_bstb);
    check("bus_adr",  bus_adr_o, adr);
    check("bus_we",   bus_we_o,  we);
    check("bus_sel",  bus_sel_o, sel);
    check("bus_wdat", bus_dat_o, wd);
    check("m0_ack",   m0_ack_o,  e_ack0);
    check("m0_rdat",  m0_dat_o,  d0);
    check("m1_ack",   m1_ack_o,  e_ack1);
    check("m1_rdat",  m1_dat_o,  d1);
    check("timeout",  timeout_o, m_tmo);

    o_grant = grant_o; o_ack1 = m1_ack_o; o_dat1 = m1_dat_o;
    o_bstb = bus_stb_o; o_tmo = timeout_o;
    if (grant_o != 2'b00 && prev_gnt == 2'b00) begin
      tlog.push_back(int'(grant_o));
      tcyc.push_back(ncyc);
    end
    prev_gnt = grant_o;
    ncyc++;

    // stall tally uses the owner of this cycle
    if (m_own == 0 || bus_ack_i || hit) m_wd = 0;
    else if (rc || rs) m_wd++;
    m_tmo = m_tmo | hit;
    if (m_own == 0) begin
      if (m0_cyc_i && m1_cyc_i && m_starve == LIMIT) begin m_own = 2; m_starve = 0; end
      else if (m0_cyc_i) begin
        m_own = 1;
        m_starve = m1_cyc_i ? ((m_starve < 255) ? m_starve + 1 : 255) : 0;
      end else if (m1_cyc_i) begin m_own = 2; m_starve = 0; end
    end else if (!rc || hit) m_own = 0;

    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    check("rst_grant",   grant_o,   2'b00);
    check("rst_bus_cyc", bus_cyc_o, 1'b0);
    check("rst_bus_stb", bus_stb_o, 1'b0);
    check("rst_m0_ack",  m0_ack_o,  1'b0);
    check("rst_m1_ack",  m1_ack_o,  1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic drop_all();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    bus_ack_i = 0; bus_dat_i = 0;
  endtask

  initial begin
    int exp_hog[10];
    int g1, nack, obs_ack, t_stb, t_ack;
    exp_hog = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    #2;
    do_reset();

    // m1 alone: read 0x100, slave acks two cycles after stb.
    tlog.delete(); tcyc.delete();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h100; m1_we_i = 0; m1_sel_i = 4'hF;
    step();
    step();
    check("t1_grant_n1", o_grant, 2'b10);
    step();
    bus_ack_i = 1; bus_dat_i = 32'h1234_5678;
    step();
    check("t1_ack", o_ack1, 1'b1);
    check("t1_rdat", o_dat1, 32'h1234_5678);
    drop_all();
    step();
    step();
    check("t1_idle_after", o_grant, 2'b00);
    check("t1_tenures", tlog.size(), 1);
    if (tlog.size() > 0) check("t1_owner", tlog[0], 2);

    // Simultaneous request from idle: m0 first, m1 after one idle cycle.
    tlog.delete(); tcyc.delete();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (e_grant == 2'b01) begin m0_cyc_i = 0; m0_stb_i = 0; end
      if (e_grant == 2'b10) begin m1_cyc_i = 0; m1_stb_i = 0; end
    end
    check("t2_tenures", tlog.size(), 2);
    if (tlog.size() >= 2) begin
      check("t2_first", tlog[0], 1);
      check("t2_second", tlog[1], 2);
      check("t2_gap", tcyc[1] - tcyc[0], 3);
    end

    // Starvation: m0 re-requests immediately, m1 always wanting the bus.
    tlog.delete(); tcyc.delete();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; g1 = 0;
    for (int i = 0; i < 200 && tlog.size() < 10; i++) begin
      step();
      if (e_grant == 2'b01) begin
        m0_cyc_i = !m0_cyc_i; m0_stb_i = m0_cyc_i;
      end
      if (e_grant == 2'b10) begin
        if (!m1_cyc_i) begin m1_cyc_i = 1; m1_stb_i = 1; end
        else begin
          g1++;
          if (g1 == 2) begin m1_cyc_i = 0; m1_stb_i = 0; g1 = 0; end
        end
      end
    end
    check("t3_tenures", tlog.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < tlog.size()) check($sformatf("t3_owner%0d", i), tlog[i], exp_hog[i]);
    drop_all();
    repeat (3) step();

    // No preemption: m0 arrives during an m1 tenure with three reads.
    do_reset();
    tlog.delete(); tcyc.delete();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h40; nack = 0; obs_ack = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      obs_ack += int'(o_ack1);
      if (e_grant == 2'b10 && !m0_cyc_i && nack == 0) begin m0_cyc_i = 1; m0_stb_i = 1; end
      if (e_grant == 2'b01) begin m0_cyc_i = 0; m0_stb_i = 0; end
      if (e_ack1) begin
        nack++;
        if (nack == 3) begin m1_cyc_i = 0; m1_stb_i = 0; end
      end
      bus_ack_i = e_bstb && !bus_ack_i;
      bus_dat_i = $urandom;
    end
    check("t4_m1_acks", obs_ack, 3);
    check("t4_tenures", tlog.size(), 2);
    if (tlog.size() >= 2) begin
      check("t4_first", tlog[0], 2);
      check("t4_second", tlog[1], 1);
    end
    drop_all();

    // Randomised traffic with occasional asynchronous resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!m0_cyc_i) m0_cyc_i = ($urandom % 4 == 0);
      else if (e_grant == 2'b01) m0_cyc_i = ($urandom % 5 != 0);
      else m0_cyc_i = ($urandom % 20 != 0);
      if (!m1_cyc_i) m1_cyc_i = ($urandom % 4 == 0);
      else if (e_grant == 2'b10) m1_cyc_i = ($urandom % 5 != 0);
      else m1_cyc_i = ($urandom % 20 != 0);
      m0_stb_i = m0_cyc_i && ($urandom % 4 != 0);
      m1_stb_i = m1_cyc_i && ($urandom % 4 != 0);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      bus_ack_i = e_bstb && ($urandom % 3 == 0);
      bus_dat_i = $urandom;
      if ($urandom % 700 == 0) do_reset();
    end
    drop_all();

    // Stalled slave.
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
    obs_ack = 0; t_stb = -1; t_ack = -1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 60 && t_ack < 0; i++) begin
      step();
      if (o_bstb && t_stb < 0) t_stb = ncyc;
      if (o_ack1 && t_ack < 0) t_ack = ncyc;
    end
    check("t6_tmo_latency", t_ack - t_stb, TMO);
    check("t6_tmo_rdat", o_dat1, 32'hFFFF_FFFF);
    step();
    check("t6_tmo_flag", o_tmo, 1'b1);
    drop_all();
    repeat (40) step();
    check("t6_tmo_sticky", o_tmo, 1'b1);
`else
    for (int i = 0; i < 1000; i++) begin
      step();
      obs_ack += int'(o_ack1);
    end
    check("t6_no_ack", obs_ack, 0);
    check("t6_no_tmo", o_tmo, 1'b0);
    check("t6_still_granted", o_grant, 2'b10);
    drop_all();
    repeat (3) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_video_arbiter.md
Name: wb_video_arbiter

Overview:
- Two-requester Wishbone arbiter that shares one memory bus between the video scanline fetch engine (m0) and the CPU data path (m1).
- Sits between the graphics-mode fetch masters and the framebuffer memory slave.
- m0 has fixed priority so scanline FIFOs are refilled within the horizontal blank.
- A bounded starvation counter guarantees the CPU a tenure after STARVE_LIMIT consecutive contested video tenures.

Parameters:
- STARVE_LIMIT, 4, consecutive contested m0 tenures after which m1 must win the next arbitration (1..255).
- TIMEOUT, 255, cycles of unacknowledged stb before watchdog termination (used only with WB_ARB_TIMEOUT_EN; 1..255).

Ports:
- clk_i  input  1  single system clock; all logic on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- m0  if_wb.slave  -  video requester (cyc, stb, adr[31:0], we, sel[3:0], dat to/from, ack).
- m1  if_wb.slave  -  CPU requester, same fields.
- bus  if_wb.master  -  shared bus to the memory slave.
- grant_o  output  2  one-hot owner: 01 = m0, 10 = m1, 00 = idle.
- timeout_o  output  1  sticky watchdog flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n_i=0): state S_IDLE, grant_o=00, starve_cnt=0, wd_cnt=0, timeout_o=0. bus.cyc, bus.stb and both requester acks drop to 0 immediately, including mid-transaction.
- States: S_IDLE, S_GRANT0, S_GRANT1. State and grant are registered.
- S_IDLE arbitration, evaluated each cycle:
  - m0.cyc & m1.cyc & starve_cnt==STARVE_LIMIT -> S_GRANT1, starve_cnt=0.
  - m0.cyc (other cases) -> S_GRANT0. starve_cnt increments, saturating, if m1.cyc=1; otherwise starve_cnt clears.
  - m1.cyc only -> S_GRANT1, starve_cnt=0.
  - No request -> remain in S_IDLE.
- Arbitration latency: cyc asserted in cycle N while in S_IDLE -> grant_o valid and the bus driven from cycle N+1.
- S_GRANTx: bus.cyc, stb, adr, we, sel and write data are combinationally muxed from the granted requester. bus.ack and bus read data route only to the granted requester.
- Non-granted requester: ack=0, read data=0.
- S_IDLE: bus.cyc=0, bus.stb=0, adr=0, sel=0, we=0.
- Tenure ends when the granted requester drops cyc (sampled at a clock edge) -> S_IDLE. Exactly one idle cycle always separates tenures, even back-to-back by the same requester.
- No preemption: a request from m0 during an m1 tenure waits until m1.cyc falls.
- A requester that drops cyc with an ack outstanding loses the ack. The arbiter returns to S_IDLE regardless.
- Simultaneous release and new request in the same cycle: release is processed first, the idle cycle follows, then arbitration.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled behaviour:
  - wd_cnt counts cycles with bus.stb|cyc high and bus.ack low in S_GRANTx. It clears on ack and on S_IDLE.
  - When wd_cnt reaches TIMEOUT, the arbiter drives a one-cycle ack to the granted requester with read data 32'hFFFFFFFF.
  - bus.cyc is forced low that cycle, timeout_o is set (sticky), and the state goes to S_IDLE next cycle.
- Disabled behaviour: no watchdog logic is built, timeout_o is tied 0, and stalled transactions wait indefinitely.

Test Plan:
- m1 only, read adr 0x100; slave acks 2 cycles after stb with 0x12345678 -> grant_o=10 from cycle N+1; m1 receives ack+0x12345678; m0.ack stays 0; grant_o returns to 00 the cycle after m1.cyc falls.
- m0 and m1 assert cyc in the same cycle from S_IDLE -> grant_o=01 first; m1 granted after m0 releases plus one idle cycle; starve_cnt=0 after m1 is granted.
- STARVE_LIMIT=4, m0 re-requests immediately after every release, m1 held high -> four m0 tenures, then grant_o=10 on the fifth arbitration; m0 follows after m1 releases.
- m0 asserts cyc during an m1 tenure with 3 outstanding word reads -> m1 keeps grant_o=10 through all 3 acks; one idle cycle follows; then grant_o=01.
- rst_n_i pulsed low mid-tenure with stb high -> bus.cyc=0 and grant_o=00 asynchronously; after release, normal arbitration resumes with starve_cnt=0.
- WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks -> requester gets ack with 0xFFFFFFFF exactly 16 cycles after stb, timeout_o=1 and remains set. Without the macro: no ack and timeout_o=0 after 1000 cycles.
